product_bcd_display: RTL and testbench
======================================

# product_bcd_display

Sequential binary-to-decimal display stage that sits directly downstream of the 4x4 switch multiplier. It captures the multiplier's binary product on a start strobe and converts it to three BCD digits with a shift-and-add-3 (double-dabble) datapath, one bit per clock. It then drives three active-low seven-segment displays with the decimal value, holding the previous result on the displays while a new conversion runs.

## Interface
- W, 8, product width in bits; legal range 4..9 (result always fits 3 decimal digits)
- BLANK_LZ, 1, 1 = blank leading-zero digits on HEX2/HEX1; 0 = show all three digits

- CLOCK_50  input  1  system clock; all state changes on rising edge
- RESET_N  input  1  synchronous, active-low reset; one clock, sampled on the CLOCK_50 rising edge
- start  input  1  conversion request; sampled only in IDLE
- product  input  W  unsigned binary value to convert; sampled in the cycle start is accepted
- busy  output  1  high while conversion in progress
- done  output  1  one-cycle pulse when new result is presented
- bcd  output  12  {hundreds, tens, ones} BCD nibbles of last result
- HEX0  output  7  ones digit, active-low segments, bit0=a .. bit6=g
- HEX1  output  7  tens digit, same encoding
- HEX2  output  7  hundreds digit, same encoding

## Operation
- FSM states: IDLE, CONVERT, DONE.
  - IDLE: if start=1, load shift register {12'b0, product} and bit counter = W-1, then go to CONVERT. Otherwise stay in IDLE.
  - CONVERT: each cycle, add 3 to every BCD nibble that is >= 5, then shift the whole {bcd, bin} register left by 1. When the counter reaches 0 after the shift, go to DONE; otherwise decrement the counter.
  - DONE: copy the BCD field into the bcd output register, update HEX0..HEX2, assert done, go to IDLE unconditionally.
- Nibble correction uses the pre-shift nibble value; the nibble is 4 bits and never exceeds 9 after the final shift.
- Segment codes (active-low): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10. Blank = 0x7F.
- Leading-zero blanking when BLANK_LZ=1:
  - HEX2 is blank if hundreds=0.
  - HEX1 is blank if hundreds=0 and tens=0.
  - HEX0 is never blanked.
- start is ignored in CONVERT and DONE. There is no queueing.
- product may change freely after the accept cycle without affecting the conversion.

## Timing
- Reset values:
  - state = IDLE; busy = 0; done = 0; bcd = 12'h000.
  - HEX0 = 0x40.
  - HEX1 and HEX2 = 0x7F when BLANK_LZ=1, otherwise 0x40.
- Accept at cycle T (IDLE, start=1):
  - busy = 1 for cycles T+1 .. T+W.
  - done = 1 and the new bcd/HEX values are visible in cycle T+W+1; busy = 0 in that cycle.
  - FSM is back in IDLE at T+W+2. Earliest next accept is T+W+2, so throughput is one conversion per W+2 cycles.
- bcd and HEX0..HEX2 change only in the DONE cycle and hold their values at all other times.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- RESET_N=0 mid-conversion aborts the conversion. In the next cycle every output equals its reset value and the partial result is discarded.
- RESET_N=0 coincident with start: reset wins and start is dropped.
- start held high continuously: a new conversion is accepted every W+2 cycles, each time product is sampled in IDLE.

## Test plan
- Reset, then start with product=0 (W=8, BLANK_LZ=1) -> done at T+9; bcd=0x000; HEX0=0x40; HEX1=HEX2=0x7F.
- product=225 (15x15, the multiplier maximum) -> at T+9: bcd=0x225; HEX2=0x24; HEX1=0x24; HEX0=0x12; busy high for exactly 8 cycles; done high for exactly 1 cycle.
- product=100, then product=7 in back-to-back conversions:
  - first result: bcd=0x100; HEX2=0x79; HEX1=0x40 (not blanked); HEX0=0x40.
  - second result: bcd=0x007; HEX1=HEX2=0x7F; HEX0=0x78.
  - second accept occurs no earlier than T+10.
- product=255 (W=8); pulse start again and change product at T+3 -> result is 0x255 with a single done pulse; the second start is ignored; displays hold the old value until T+9.
- Start conversion of 99, drive RESET_N=0 at T+4 for one cycle -> all outputs return to reset values at T+5; no done pulse; a new start after release converts normally.
- BLANK_LZ=0, product=5 -> HEX2=0x40, HEX1=0x40, HEX0=0x12; reset values of HEX1/HEX2 = 0x40.

Source files
------------

// File: rtl/product_bcd_display.sv
// rtl/product_bcd_display.sv - product to 3-digit BCD converter driving seven-segment displays
// Shift-and-add-3 conversion, one product bit per clock, result held on the displays between conversions.
module product_bcd_display #(
   parameter int W        = 8,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic         CLOCK_50,
   input  logic         RESET_N,
   input  logic         start,
   input  logic [W-1:0] product,
   output logic         busy,
   output logic         done,
   output logic [11:0]  bcd,
   output logic [6:0]   HEX0,
   output logic [6:0]   HEX1,
   output logic [6:0]   HEX2
);

   typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_ZERO  = 7'h40;
   localparam logic [6:0] HEX_HI_RST = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

   state_t        state_q, state_d;
   logic [W+11:0] sr_q, sr_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [11:0]   bcd_q, bcd_d;
   logic [6:0]    hex0_q, hex0_d;
   logic [6:0]    hex1_q, hex1_d;
   logic [6:0]    hex2_q, hex2_d;

   logic [11:0]   bcd_adj;
   logic [W+11:0] sr_shift;
   logic [11:0]   bcd_new;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   always_comb begin
      // Correction looks at the pre-shift nibble so each digit stays 0..9 after doubling.
      bcd_adj = sr_q[W+11:W];
      for (int i = 0; i < 3; i++) begin
         if (bcd_adj[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
         end
      end
      sr_shift = {bcd_adj, sr_q[W-1:0]} << 1;
      bcd_new  = sr_shift[W+11:W];

      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      bcd_d   = bcd_q;
      hex0_d  = hex0_q;
      hex1_d  = hex1_q;
      hex2_d  = hex2_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d    = {12'b0, product};
               cnt_d   = 4'(W - 1);
               busy_d  = 1'b1;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            sr_d = sr_shift;
            if (cnt_q == 4'd0) begin
               // Outputs load on the way into DONE so they are visible during the DONE cycle.
               state_d = DONE;
               done_d  = 1'b1;
               bcd_d   = bcd_new;
               hex0_d  = seg7(bcd_new[3:0]);
               hex1_d  = (BLANK_LZ && bcd_new[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd_new[7:4]);
               hex2_d  = (BLANK_LZ && bcd_new[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd_new[11:8]);
            end else begin
               cnt_d  = cnt_q - 4'd1;
               busy_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= 12'h000;
         hex0_q  <= SEG_ZERO;
         hex1_q  <= HEX_HI_RST;
         hex2_q  <= HEX_HI_RST;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bcd_q   <= bcd_d;
         hex0_q  <= hex0_d;
         hex1_q  <= hex1_d;
         hex2_q  <= hex2_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;
   assign HEX0 = hex0_q;
   assign HEX1 = hex1_q;
   assign HEX2 = hex2_q;

endmodule

// File: tb/tb_product_bcd_display.sv
// tb/tb_product_bcd_display.sv - randomized self-checking bench for product_bcd_display
// Two instances (blanking on/off) share stimulus and are checked against a decimal reference model.
module tb_product_bcd_display;

   localparam int W = 8;
   localparam logic [6:0] SEG [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         start;
   logic [W-1:0] product;
   logic         busy_a, done_a, busy_b, done_b;
   logic [11:0]  bcd_a, bcd_b;
   logic [6:0]   h0a, h1a, h2a, h0b, h1b, h2b;

   int n_vec = 0;
   int n_err = 0;
   int held_val = 0;

   product_bcd_display #(.W(W), .BLANK_LZ(1'b1)) u_dut (
      .CLOCK_50(clk), .RESET_N(rst_n), .start(start), .product(product),
      .busy(busy_a), .done(done_a), .bcd(bcd_a), .HEX0(h0a), .HEX1(h1a), .HEX2(h2a)
   );

   product_bcd_display #(.W(W), .BLANK_LZ(1'b0)) u_dut_nb (
      .CLOCK_50(clk), .RESET_N(rst_n), .start(start), .product(product),
      .busy(busy_b), .done(done_b), .bcd(bcd_b), .HEX0(h0b), .HEX1(h1b), .HEX2(h2b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [11:0] bcd_of(input int v);
      return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
   endfunction

   function automatic logic [6:0] hex_of(input int v, input int digit, input bit blank);
      int h, t, o;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      if (digit == 0) return SEG[o];
      if (digit == 1) return (blank && h == 0 && t == 0) ? 7'h7F : SEG[t];
      return (blank && h == 0) ? 7'h7F : SEG[h];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_display(input string tag, input int v);
      check({tag, ".bcd_a"}, 32'(bcd_a), 32'(bcd_of(v)));
      check({tag, ".bcd_b"}, 32'(bcd_b), 32'(bcd_of(v)));
      check({tag, ".hex0_a"}, 32'(h0a), 32'(hex_of(v, 0, 1'b1)));
      check({tag, ".hex1_a"}, 32'(h1a), 32'(hex_of(v, 1, 1'b1)));
      check({tag, ".hex2_a"}, 32'(h2a), 32'(hex_of(v, 2, 1'b1)));
      check({tag, ".hex0_b"}, 32'(h0b), 32'(hex_of(v, 0, 1'b0)));
      check({tag, ".hex1_b"}, 32'(h1b), 32'(hex_of(v, 1, 1'b0)));
      check({tag, ".hex2_b"}, 32'(h2b), 32'(hex_of(v, 2, 1'b0)));
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".busy"}, 32'(busy_a), 32'd0);
      check({tag, ".done"}, 32'(done_a), 32'd0);
      check({tag, ".busy_b"}, 32'(busy_b), 32'd0);
      check({tag, ".done_b"}, 32'(done_b), 32'd0);
      check({tag, ".bcd_a"}, 32'(bcd_a), 32'h000);
      check({tag, ".bcd_b"}, 32'(bcd_b), 32'h000);
      check({tag, ".hex0_a"}, 32'(h0a), 32'h40);
      check({tag, ".hex1_a"}, 32'(h1a), 32'h7F);
      check({tag, ".hex2_a"}, 32'(h2a), 32'h7F);
      check({tag, ".hex0_b"}, 32'(h0b), 32'h40);
      check({tag, ".hex1_b"}, 32'(h1b), 32'h40);
      check({tag, ".hex2_b"}, 32'(h2b), 32'h40);
   endtask

   // Accept in the current (IDLE) cycle T, optionally re-pulse start at T+3.
   task automatic run_conv(input int p, input bit restart);
      start   = 1'b1;
      product = 8'(p);
      tick;
      start   = 1'b0;
      product = 8'($urandom);
      for (int i = 1; i <= W; i++) begin
         check("conv.busy", 32'(busy_a), 32'd1);
         check("conv.done", 32'(done_a), 32'd0);
         check_display("conv.hold", held_val);
         if (restart && i == 3) begin
            start   = 1'b1;
            product = 8'($urandom);
         end else begin
            start = 1'b0;
         end
         tick;
      end
      start = 1'b0;
      check("res.busy", 32'(busy_a), 32'd0);
      check("res.done", 32'(done_a), 32'd1);
      check("res.done_b", 32'(done_b), 32'd1);
      check_display("res", p);
      held_val = p;
      tick;
      check("post.done", 32'(done_a), 32'd0);
      check("post.busy", 32'(busy_a), 32'd0);
      check_display("post.hold", held_val);
   endtask

   // start held high: accepts every W+2 cycles, product changes every cycle.
   task automatic run_stream(input int n);
      int acc;
      acc   = 0;
      start = 1'b1;
      for (int k = 0; k < n * (W + 2); k++) begin
         product = 8'($urandom);
         if (k % (W + 2) == 0) acc = int'(product);
         tick;
         check("strm.done", 32'(done_a), 32'(((k + 1) % (W + 2)) == W + 1));
         check("strm.busy", 32'(busy_a),
               32'(((k + 1) % (W + 2)) >= 1 && ((k + 1) % (W + 2)) <= W));
         if (((k + 1) % (W + 2)) == W + 1) begin
            check_display("strm", acc);
            held_val = acc;
         end
      end
      start = 1'b0;
      tick;
      check("strm.idle", 32'(busy_a), 32'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      product = '0;
      tick;
      check_reset("rst");
      rst_n = 1'b1;
      tick;
      check_reset("rst.idle");

      run_conv(0, 1'b0);
      run_conv(225, 1'b0);
      run_conv(100, 1'b0);
      run_conv(7, 1'b0);
      run_conv(255, 1'b1);
      run_conv(5, 1'b0);

      // Reset asserted in cycle T+4 of a conversion of 99.
      start   = 1'b1;
      product = 8'd99;
      tick;
      start = 1'b0;
      tick;
      tick;
      tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      check_reset("abort");
      held_val = 0;
      for (int i = 0; i < 12; i++) begin
         check("abort.nodone", 32'(done_a), 32'd0);
         tick;
      end
      run_conv(99, 1'b0);

      // Reset coincident with start: start dropped.
      rst_n   = 1'b0;
      start   = 1'b1;
      product = 8'd200;
      tick;
      rst_n = 1'b1;
      start = 1'b0;
      held_val = 0;
      check_reset("rst_start");
      tick;
      check("rst_start.busy", 32'(busy_a), 32'd0);
      for (int i = 0; i < W + 2; i++) tick;
      check("rst_start.nodone", 32'(done_a), 32'd0);
      check_display("rst_start.hold", held_val);

      run_stream(3);

      repeat (25) run_conv(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
